// File: rtl/kbd_matrix_wb_responder.sv
// Keyboard matrix image: RP2040 writes rows over pipelined Wishbone, and the CPU
// selects a row via PIA1 PORTA and reads it back through PORTB with a bus override.
module kbd_matrix_wb_responder #(
    parameter int unsigned KBD_ROW_COUNT  = 10,
    parameter int unsigned KBD_ADDR_WIDTH = 4,
    parameter logic [15:0] PIA_BASE       = 16'hE810
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_i,
    input  logic [KBD_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [7:0]                wb_data_i,
    output logic [7:0]                wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cycle_i,
    input  logic                      wb_strobe_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
    input  logic [15:0]               cpu_addr_i,
    input  logic [7:0]                cpu_data_i,
    input  logic                      cpu_we_i,
    input  logic                      cpu_wr_strobe_i,
    input  logic                      cpu_rd_i,
    output logic [7:0]                kbd_data_o,
    output logic                      kbd_oe_o
);

    localparam logic [15:0] PiaPortA = PIA_BASE;
    localparam logic [15:0] PiaPortB = 16'(PIA_BASE + 16'd2);

    logic [7:0]                rows_q [KBD_ROW_COUNT];
    logic [7:0]                rows_d [KBD_ROW_COUNT];
    logic [KBD_ADDR_WIDTH-1:0] row_sel_q, row_sel_d;
    logic                      ack_q, ack_d;
    logic [7:0]                wb_data_q, wb_data_d;
    logic [7:0]                kbd_data_q, kbd_data_d;
    logic                      kbd_oe_q, kbd_oe_d;
    logic                      wb_accept;
    logic [7:0]                wb_rd_byte;
    logic [7:0]                kbd_rd_byte;

    assign wb_stall_o = wb_reset_i;
    assign wb_accept  = wb_cycle_i & wb_strobe_i & ~wb_stall_o;

    always_comb begin
        wb_rd_byte  = 8'hFF;
        kbd_rd_byte = 8'hFF;
        // Unimplemented row indices match no entry and so read as 8'hFF / drop writes.
        for (int i = 0; i < KBD_ROW_COUNT; i++) begin
            rows_d[i] = rows_q[i];
            if (KBD_ADDR_WIDTH'(i) == wb_addr_i) begin
                wb_rd_byte = rows_q[i];
                if (wb_accept && wb_we_i) begin
                    rows_d[i] = wb_data_i;
                end
            end
            if (KBD_ADDR_WIDTH'(i) == row_sel_q) begin
                kbd_rd_byte = rows_q[i];
            end
        end
    end

    always_comb begin
        ack_d      = wb_accept;
        wb_data_d  = wb_data_q;
        row_sel_d  = row_sel_q;
        kbd_data_d = kbd_rd_byte;
        kbd_oe_d   = cpu_rd_i & ~cpu_we_i & (cpu_addr_i == PiaPortB);
        if (wb_accept && !wb_we_i) begin
            wb_data_d = wb_rd_byte;
        end
        if (cpu_wr_strobe_i && cpu_we_i && cpu_addr_i == PiaPortA) begin
            row_sel_d = cpu_data_i[KBD_ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            for (int i = 0; i < KBD_ROW_COUNT; i++) begin
                rows_q[i] <= 8'hFF;
            end
            row_sel_q  <= '0;
            ack_q      <= 1'b0;
            wb_data_q  <= 8'h00;
            kbd_data_q <= 8'hFF;
            kbd_oe_q   <= 1'b0;
        end else begin
            for (int i = 0; i < KBD_ROW_COUNT; i++) begin
                rows_q[i] <= rows_d[i];
            end
            row_sel_q  <= row_sel_d;
            ack_q      <= ack_d;
            wb_data_q  <= wb_data_d;
            kbd_data_q <= kbd_data_d;
            kbd_oe_q   <= kbd_oe_d;
        end
    end

    // An initiator that drops cycle before the ack aborts; the write has already landed.
    assign wb_ack_o   = ack_q & wb_cycle_i;
    assign wb_data_o  = wb_data_q;
    assign kbd_data_o = kbd_data_q;
    assign kbd_oe_o   = kbd_oe_q;

endmodule
